stage_ma: RTL and testbench
===========================

Name: stage_ma

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline.
- Consumes the EX-MA pipeline register (ex_ma_reg_t) and runs loads and stores on a variable-latency req/gnt/rvalid data-memory port.
- Aligns and extends load data, and produces the MA-WB pipeline register (ma_wb_reg_t).
- Raises ma_stall_o while an access is outstanding. The hazard unit then freezes IF..EX, including the EX-MA register.

Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ex_ma_i  in  ex_ma_reg_t  EX-MA register contents. Fields used: valid, alu_result (address), dmem_data, dmem_rd_en, dmem_wr_en, dmem_size, dmem_sign, reg_wr_en, reg_wr_sel, reg_wr_addr, pc_plus_four.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address, {alu_result[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data, word lane.
- ma_stall_o  out  1  MA cannot complete this cycle.
- misalign_o  out  1  current access is misaligned or has an illegal size.
- ma_wb_reg_o  out  ma_wb_reg_t  fields: valid, reg_wr_en, reg_wr_sel, reg_wr_addr, alu_result, pc_plus_four, load_data.

Behaviour:
- Reset: clk is the single clock; rst_ni is asynchronous and active-low.
  - While rst_ni=0: FSM=IDLE; ma_wb_reg_o.valid=0, reg_wr_en=0, other fields 0.
  - dmem_req_o, dmem_we_o, ma_stall_o and misalign_o are forced to 0 combinationally.
- Access condition: acc = valid & (dmem_rd_en | dmem_wr_en) & ~misalign.
  - misalign = valid & (rd_en|wr_en) & ((size==01 & a[0]) | (size==10 & a[1:0]!=0) | size==11), where a = alu_result.
- Byte enables:
  - byte: 4'b0001<<a[1:0]
  - half: 4'b0011<<a[1:0]
  - word: 4'b1111
- Write data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- FSM states IDLE, REQ, WAIT_R:
  - IDLE: if acc, dmem_req_o=1 in the same cycle. If gnt, a store completes and stays IDLE; a load goes to WAIT_R. Without gnt, go to REQ.
  - REQ: hold req with identical addr/we/be/wdata until gnt. Then a store goes to IDLE, a load goes to WAIT_R.
  - WAIT_R: req=0. On rvalid, capture the load result and go to IDLE.
  - The memory never returns rvalid in the same cycle as gnt.
  - rvalid is ignored in IDLE and REQ, which includes stale responses after reset.
- Completion and stall:
  - complete = (store & gnt) | (state==WAIT_R & rvalid).
  - ma_stall_o = acc & ~complete. This is purely combinational from state and inputs.
  - Minimum load latency is 1 stall cycle. Zero-wait stores do not stall.
- Load data:
  - sh = rdata >> (8*a[1:0]).
  - byte: dmem_sign ? {24'b0,sh[7:0]} : {{24{sh[7]}},sh[7:0]}.
  - half: same pattern with 16 bits.
  - word: sh.
  - dmem_sign=1 means unsigned, matching func3[2].
- MA-WB register (posedge clk):
  - If ma_stall_o: insert a bubble (valid=0, reg_wr_en=0); other fields don't-care.
  - Else: valid=ex_ma_i.valid, reg_wr_en=ex_ma_i.reg_wr_en & ~misalign_o, load_data = the extended result (loads) or 0.
  - All other fields pass through.
- Misaligned access: no request, no stall, misalign_o=1 while the instruction sits in MA. It retires with reg_wr_en=0.
- Squashed instructions (valid=0): never issue a request, whatever rd_en/wr_en say.
- ex_ma_i is stable while ma_stall_o=1. The hazard unit gives MA stall priority over squash.
- Reset mid-access: FSM returns to IDLE immediately and req drops asynchronously. The access is abandoned.

Test Plan:
1. SW a=0x100, d=0xDEADBEEF, gnt same cycle -> req for 1 cycle, be=1111, wdata=0xDEADBEEF, ma_stall_o never 1; next edge WB valid=1, reg_wr_en=0.
2. LB a=0x103, gnt cycle0, rvalid cycle2 with rdata=0x80AABBCC -> stall high cycles 0-1; load_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
3. SH a=0x102, d=0x00001234, gnt delayed 3 cycles -> req/addr=0x100/be=1100/wdata=0x12341234 stable for 4 cycles; stall high 3 cycles; WB receives 3 bubbles, then the store.
4. LW a=0x101 -> dmem_req_o=0, misalign_o=1, ma_stall_o=0; WB valid=1, reg_wr_en=0.
5. rst_ni low while in WAIT_R -> req, stall and WB valid are 0 immediately; after release, an rvalid pulse is ignored and the FSM stays IDLE.
6. valid=0 with dmem_rd_en=1, then back-to-back LW 0x200/0x204 (rvalid 1 cycle after gnt) -> no request for the bubble; two requests, load_data matches each rdata in order.

Source files
------------

// File: rtl/stage_ma.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid data port,
// aligns/extends load data and fills the MA-WB pipeline register.
package stage_ma_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] dmem_data;
    logic        dmem_rd_en;
    logic        dmem_wr_en;
    logic [1:0]  dmem_size;
    logic        dmem_sign;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_sel;
    logic [4:0]  reg_wr_addr;
    logic [31:0] pc_plus_four;
  } ex_ma_reg_t;

  typedef struct packed {
    logic        valid;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_sel;
    logic [4:0]  reg_wr_addr;
    logic [31:0] alu_result;
    logic [31:0] pc_plus_four;
    logic [31:0] load_data;
  } ma_wb_reg_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } ma_state_e;

endpackage

// Handshake: dmem_req_o is held with identical addr/we/be/wdata until the
// cycle dmem_gnt_i is high; a load's data arrives on dmem_rvalid_i in a later
// cycle. rvalid outside WAIT_R is ignored.
module stage_ma
  import stage_ma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  ex_ma_reg_t      ex_ma_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            ma_stall_o,
  output logic            misalign_o,
  output ma_wb_reg_t      ma_wb_reg_o,
  output logic [1:0]      dbg_state
);

  ma_state_e       state;
  ma_wb_reg_t      wb_q;
  logic [1:0]      ofs;
  logic            access_rq;
  logic            misalign;
  logic            acc;
  logic            is_store;
  logic            is_load;
  logic            req;
  logic            complete;
  logic            stall;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  assign ofs       = ex_ma_i.alu_result[1:0];
  assign access_rq = ex_ma_i.valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);

  always_comb begin
    misalign = 1'b0;
    if (access_rq) begin
      case (ex_ma_i.dmem_size)
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = ofs[0];
        2'b10:   misalign = |ofs;
        default: misalign = 1'b1;
      endcase
    end
  end

  assign acc      = access_rq & ~misalign;
  assign is_store = acc & ex_ma_i.dmem_wr_en;
  assign is_load  = acc & ~ex_ma_i.dmem_wr_en;

  always_comb begin
    be    = 4'b1111;
    wdata = ex_ma_i.dmem_data;
    case (ex_ma_i.dmem_size)
      2'b00: begin
        be    = 4'b0001 << ofs;
        wdata = {4{ex_ma_i.dmem_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << ofs;
        wdata = {2{ex_ma_i.dmem_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = ex_ma_i.dmem_data;
      end
    endcase
  end

  // The request is live in IDLE (first cycle) and REQ (waiting for grant).
  assign req      = acc & (state != ST_WAIT_R);
  assign complete = (is_store & req & dmem_gnt_i) | ((state == ST_WAIT_R) & dmem_rvalid_i);
  assign stall    = acc & ~complete;

  // Reset gates the handshake outputs so an abandoned access drops at once.
  assign dmem_req_o   = req & rst_ni;
  assign dmem_we_o    = is_store & rst_ni;
  assign dmem_addr_o  = {ex_ma_i.alu_result[XLEN-1:2], 2'b00};
  assign dmem_be_o    = be;
  assign dmem_wdata_o = wdata;
  assign ma_stall_o   = stall & rst_ni;
  assign misalign_o   = misalign & rst_ni;
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_REQ: begin
          if (acc) begin
            if (dmem_gnt_i) state <= is_store ? ST_IDLE : ST_WAIT_R;
            else            state <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_R: begin
          if (dmem_rvalid_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // dmem_sign=1 selects zero extension (mirrors funct3[2]).
  assign shifted = dmem_rdata_i >> {ofs, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (ex_ma_i.dmem_size)
      2'b00: load_ext = ex_ma_i.dmem_sign ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = ex_ma_i.dmem_sign ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_q <= '0;
    end else begin
      wb_q.reg_wr_sel   <= ex_ma_i.reg_wr_sel;
      wb_q.reg_wr_addr  <= ex_ma_i.reg_wr_addr;
      wb_q.alu_result   <= ex_ma_i.alu_result;
      wb_q.pc_plus_four <= ex_ma_i.pc_plus_four;
      if (stall) begin
        wb_q.valid     <= 1'b0;
        wb_q.reg_wr_en <= 1'b0;
        wb_q.load_data <= '0;
      end else begin
        wb_q.valid     <= ex_ma_i.valid;
        wb_q.reg_wr_en <= ex_ma_i.reg_wr_en & ~misalign;
        wb_q.load_data <= is_load ? load_ext : '0;
      end
    end
  end

  assign ma_wb_reg_o = wb_q;

endmodule

// File: tb/tb_stage_ma.sv
// Bench for stage_ma: directed scenarios plus random instructions against a
// transaction-level model of the memory stage.
module tb_stage_ma;
  import stage_ma_pkg::*;

  localparam int W = 32;

  typedef struct {
    ex_ma_reg_t  ex;
    int          g;      // cycles before grant
    int          r;      // cycles from grant to rvalid
    logic [31:0] rdata;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_ma_reg_t  ex_ma;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        req, we, stall, mis;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  ma_wb_reg_t  wb;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  stage_ma dut (
    .clk(clk), .rst_ni(rst_n), .ex_ma_i(ex_ma),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata), .ma_stall_o(stall), .misalign_o(mis),
    .ma_wb_reg_o(wb), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_misalign(input ex_ma_reg_t t);
    if (!(t.valid && (t.dmem_rd_en || t.dmem_wr_en))) return 1'b0;
    if (t.dmem_size == 2'd3) return 1'b1;
    return (t.alu_result % nbytes(t.dmem_size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input ex_ma_reg_t t);
    logic [3:0] v;
    int off = int'(t.alu_result % 4);
    int n = nbytes(t.dmem_size);
    for (int i = 0; i < 4; i++) v[i] = (i >= off) && (i < off + n);
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input ex_ma_reg_t t);
    logic [31:0] v;
    int n = nbytes(t.dmem_size);
    for (int i = 0; i < 4; i++) v[8*i +: 8] = t.dmem_data[8*(i % n) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_load(input ex_ma_reg_t t, input logic [31:0] d);
    logic [31:0] v = '0;
    logic [31:0] ones = '1;
    int off = int'(t.alu_result % 4);
    int n = nbytes(t.dmem_size);
    for (int j = 0; j < n; j++) v[8*j +: 8] = d[8*(off + j) +: 8];
    if (!t.dmem_sign && n < 4 && v[8*n-1]) v = v | (ones << (8*n));
    return v;
  endfunction

  function automatic instr_t mk(input logic valid, input logic rd, input logic wr,
                                input logic [1:0] size, input logic sign,
                                input logic [31:0] a, input logic [31:0] d,
                                input int g, input int r, input logic [31:0] rd_data);
    instr_t t;
    t.ex.valid        = valid;
    t.ex.alu_result   = a;
    t.ex.dmem_data    = d;
    t.ex.dmem_rd_en   = rd;
    t.ex.dmem_wr_en   = wr;
    t.ex.dmem_size    = size;
    t.ex.dmem_sign    = sign;
    t.ex.reg_wr_en    = !wr;
    t.ex.reg_wr_sel   = 2'($urandom_range(0, 3));
    t.ex.reg_wr_addr  = 5'($urandom_range(1, 31));
    t.ex.pc_plus_four = $urandom & 32'hFFFF_FFFC;
    t.g = g;
    t.r = r;
    t.rdata = rd_data;
    return t;
  endfunction

  task automatic check_wb();
    logic [W-1:0] full;
    full = exp_q.pop_front();
    check("wb_valid", 32'(wb.valid), exp_q.pop_front());
    check("wb_reg_wr_en", 32'(wb.reg_wr_en), exp_q.pop_front());
    if (full[0]) begin
      check("wb_load_data", wb.load_data, exp_q.pop_front());
      check("wb_alu_result", wb.alu_result, exp_q.pop_front());
      check("wb_pc_plus_four", wb.pc_plus_four, exp_q.pop_front());
      check("wb_rd", 32'({wb.reg_wr_sel, wb.reg_wr_addr}), exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left just after a rising edge; length comes from the model.
  task automatic run_instr(input instr_t t);
    logic a_mis, acc, is_st, is_ld, exp_req, last;
    int len;
    a_mis = m_misalign(t.ex);
    acc   = t.ex.valid && (t.ex.dmem_rd_en || t.ex.dmem_wr_en) && !a_mis;
    is_st = acc && t.ex.dmem_wr_en;
    is_ld = acc && !t.ex.dmem_wr_en;
    len   = is_st ? t.g + 1 : is_ld ? t.g + t.r + 1 : 1;
    for (int k = 0; k < len; k++) begin
      ex_ma  = t.ex;
      gnt    = acc && (k == t.g);
      rvalid = is_ld && (k == t.g + t.r);
      rdata  = rvalid ? t.rdata : $urandom;
      #2;
      exp_req = acc && (k <= t.g);
      last    = (k == len - 1);
      check("req", 32'(req), 32'(exp_req));
      if (exp_req) begin
        check("we", 32'(we), 32'(is_st));
        check("addr", addr, t.ex.alu_result & ~32'd3);
        check("be", 32'(be), 32'(m_be(t.ex)));
        if (is_st) check("wdata", wdata, m_wdata(t.ex));
      end
      check("misalign", 32'(mis), 32'(a_mis));
      check("stall", 32'(stall), 32'(acc && !last));
      if (acc && !last) begin
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
      end else begin
        exp_q.push_back(32'd1);
        exp_q.push_back(32'(t.ex.valid));
        exp_q.push_back(32'(t.ex.reg_wr_en && !a_mis));
        exp_q.push_back(is_ld ? m_load(t.ex, t.rdata) : 32'd0);
        exp_q.push_back(t.ex.alu_result);
        exp_q.push_back(t.ex.pc_plus_four);
        exp_q.push_back(32'({t.ex.reg_wr_sel, t.ex.reg_wr_addr}));
      end
      @(posedge clk);
      #1;
      check_wb();
    end
    gnt    = 1'b0;
    rvalid = 1'b0;
  endtask

  task automatic reset_mid_access();
    instr_t t;
    t = mk(1, 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 0, 4, 32'h1234_5678);
    ex_ma = t.ex;
    gnt = 1'b1;
    rvalid = 1'b0;
    @(posedge clk);
    #1;
    gnt = 1'b0;
    #2;
    check("rst_pre_stall", 32'(stall), 32'd1);
    check("rst_pre_req", 32'(req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_wb_valid", 32'(wb.valid), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    t = mk(0, 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 0, 1, 32'h0);
    ex_ma = t.ex;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rvalid = 1'b1;
    rdata  = $urandom;
    #2;
    check("stale_rvalid_req", 32'(req), 32'd0);
    check("stale_rvalid_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    check("stale_rvalid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stale_rvalid_wb_valid", 32'(wb.valid), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    instr_t t;
    rst_n  = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    t = mk(1, 1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 0, 1, 32'h0);
    ex_ma = t.ex;
    #12;
    check("reset_req", 32'(req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_misalign", 32'(mis), 32'd0);
    check("reset_we", 32'(we), 32'd0);
    check("reset_wb_valid", 32'(wb.valid), 32'd0);
    check("reset_wb_reg_wr_en", 32'(wb.reg_wr_en), 32'd0);
    check("reset_wb_alu_result", wb.alu_result, 32'd0);
    check("reset_wb_load_data", wb.load_data, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    t = mk(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    ex_ma = t.ex;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(mk(1, 0, 1, 2'd2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'h0));
    run_instr(mk(1, 1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 0, 2, 32'h80AA_BBCC));
    run_instr(mk(1, 1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 0, 2, 32'h80AA_BBCC));
    run_instr(mk(1, 0, 1, 2'd1, 0, 32'h0000_0102, 32'h0000_1234, 3, 1, 32'h0));
    run_instr(mk(1, 1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 0, 1, 32'h0));
    reset_mid_access();
    run_instr(mk(0, 1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 0, 1, 32'h0));
    run_instr(mk(1, 1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 0, 1, $urandom));
    run_instr(mk(1, 1, 0, 2'd2, 0, 32'h0000_0204, 32'h0, 0, 1, $urandom));

    for (int n = 0; n < 250; n++) begin
      int op;
      logic [1:0] size;
      op   = $urandom_range(0, 2);
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t = mk($urandom_range(0, 7) != 0, op == 0, op == 1, size, 1'($urandom_range(0, 1)),
             $urandom & 32'h0000_0FFF, $urandom, $urandom_range(0, 3),
             $urandom_range(1, 3), $urandom);
      run_instr(t);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
